robot_tick_generator: RTL
=========================

# robot_tick_generator

Parametrised multi-channel timebase for the HC-SR04 robot design, running entirely in the 125 MHz domain. Produces one single-cycle tick enable per channel instead of divided clocks. Each channel's divisor is reprogrammable at run time through a valid/ready port and changes without glitches. Sensor, trigger and motor-PWM logic use the ticks as clock enables.

## Interface
- `CLOCK_FREQ`, 125_000_000, input clock frequency in Hz (documentation and default derivation only)
- `NUM_CH`, 3, number of tick channels (1..16)
- `DIV_W`, 27, divisor and counter width; covers 1 Hz at 125 MHz
- `DEFAULT_DIVS`, {27'd6_250_000, 27'd125_000, 27'd125}, flat NUM_CH*DIV_W vector; channel i is slice [i*DIV_W +: DIV_W]; defaults are ch0 = 1 MHz, ch1 = 1 kHz, ch2 = 20 Hz
- `clk_125mhz`, in, 1, system clock; the only clock
- `reset_n`, in, 1, synchronous active-low reset
- `ch_en`, in, NUM_CH, per-channel run enable
- `sync`, in, 1, single-cycle realign of all channels
- `cfg_valid`, in, 1, divisor update request
- `cfg_ready`, out, 1, update can be accepted this cycle
- `cfg_chan`, in, clog2(NUM_CH) (minimum 1), target channel
- `cfg_div`, in, DIV_W, new divisor D
- `cfg_err`, out, 1, one-cycle pulse when a request is rejected
- `tick`, out, NUM_CH, one-cycle enable pulses
- `sq`, out, NUM_CH, square-wave outputs; present only with `TICK_SQUARE_EN`

## Operation
- Per channel: counter `cnt`, active divisor `div`, pending divisor `pdiv`, pending flag `pend`.
- Reset (`reset_n` = 0 at an edge):
  - `cnt` = 0, `div` = DEFAULT_DIVS slice, `pend` = 0.
  - `tick` = 0, `sq` = 0, `cfg_err` = 0.
- Enabled channel: `cnt` counts 0..div-1 and wraps to 0.
  - Terminal cycle is `cnt` == div-1.
  - `tick[i]` is registered and high for exactly the one cycle after the terminal edge, so period = div cycles.
- Disabled channel (`ch_en[i]` = 0):
  - `cnt` held at 0, `tick[i]` = 0, `sq[i]` = 0.
  - A pending divisor is applied on the next edge.
  - Re-enable restarts from `cnt` = 0; the first tick comes div cycles later.
- Config handshake:
  - A transfer happens when `cfg_valid` and `cfg_ready` are both high at an edge.
  - `cfg_ready` = !pend[cfg_chan] and cfg_chan < NUM_CH. It is combinational from `cfg_chan` and contains no path from `cfg_valid`.
  - Accepted with `cfg_div` >= 2: `pdiv` ← cfg_div, `pend` ← 1.
  - Accepted with `cfg_div` < 2: the request is consumed, the divisor is unchanged, and `cfg_err` pulses on the next cycle.
  - A request to a channel with `pend` = 1 stalls (`cfg_ready` = 0) until that channel's divisor is applied.
  - A request with cfg_chan >= NUM_CH is never ready.
- Glitch-free apply: at the terminal edge, `div` ← `pdiv`, `pend` ← 0 and `cnt` ← 0. The tick for the finishing period still fires.
- `sync` high at an edge:
  - All `cnt` ← 0.
  - All `tick` forced 0 for the following cycle.
  - All pending divisors applied.
- Simultaneous events:
  - `sync` beats a terminal count: no tick is emitted.
  - `reset_n` = 0 beats everything.
  - A config accepted on the same edge as that channel's terminal count becomes pending. It is applied at the next terminal count, not the current one.

## Timing
- Edge 0 is the first edge with `reset_n` = 1. An enabled channel with divisor D has `tick` high in the cycles after edges D-1, 2D-1, and so on.
- Tick latency from terminal count: 1 cycle, registered. All outputs are registered except `cfg_ready`.
- A new divisor takes effect at most old-D cycles after acceptance. The first period at the new D starts on the apply edge.
- `cfg_err`: 1-cycle pulse, 1 cycle after the rejecting edge.
- Reset in mid-period: counters clear on that edge and no partial tick is emitted.

## Configuration
- `TICK_SQUARE_EN` defined: `sq[i]` is a registered output.
  - Low while cnt < div/2 (integer division), high otherwise: high for ceil(D/2) cycles, low for floor(D/2).
  - Rising edge of `sq[i]` is D/2 cycles after `cnt` = 0.
  - Follows the same reset, disable and `sync` clearing as `tick`.
- Not defined: the `sq` port and its logic are absent. All other behaviour is identical.

## Test plan
- Bench setup: NUM_CH = 3, DEFAULT_DIVS = {6, 5, 4}, all `ch_en` high.
- Reset release: ticks are periodic at 4, 5 and 6 cycles; the first ch0 tick is after edge 3; `cfg_ready` = 1.
- Write ch1 D = 8 in mid-period: the current 5-cycle period completes with its tick, the next period is 8, and `cfg_ready` for ch1 is low until the apply edge.
- Write ch2 D = 1: accepted, `cfg_err` pulses once, ch2 period stays 6.
- `sync` on the same cycle as ch0's terminal count: no ch0 tick; all channels restart, and ticks fire after 4, 5 and 6 further cycles.
- `ch_en[0]` low for 10 cycles, then high: no ticks while disabled; the first tick comes 4 cycles after re-enable. Assert `reset_n` low in mid-period: all outputs are 0 on the next cycle.
- With `TICK_SQUARE_EN`: ch1 (D = 5) gives `sq` low 2 cycles and high 3 cycles; ch0 (D = 4) gives 2 low and 2 high.

Source files
------------

// File: rtl/robot_tick_generator_if.sv
// Divisor config port: valid/ready request plus reject pulse.
// master drives valid/chan/div; slave returns ready/err.
interface robot_tick_generator_if #(
  parameter int NUM_CH = 3,
  parameter int DIV_W  = 27
);
  localparam int CH_W =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_chan,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_chan,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/robot_tick_generator.sv
// Multi-channel tick-enable timebase with glitch-free
// run-time divisors. Ports: clk_125mhz, reset_n (sync,
// active low), ch_en, sync, cfg (config interface),
// tick, and sq when TICK_SQUARE_EN is defined.
module robot_tick_generator #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int NUM_CH     = 3,
  parameter int DIV_W      = 27,
  parameter logic [NUM_CH*DIV_W-1:0] DEFAULT_DIVS =
    {27'd6_250_000, 27'd125_000, 27'd125}
) (
  input  logic              clk_125mhz,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  robot_tick_generator_if.slave cfg,
  output logic [NUM_CH-1:0] tick
`ifdef TICK_SQUARE_EN
  ,
  output logic [NUM_CH-1:0] sq
`endif
);
  localparam int CH_W =
    (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

  if (CLOCK_FREQ <= 0 || NUM_CH < 1 || NUM_CH > 16)
  begin : g_bad_cfg
    $error("robot_tick_generator: bad parameters");
  end

  logic [DIV_W-1:0] r_cnt  [NUM_CH];
  logic [DIV_W-1:0] r_div  [NUM_CH];
  logic [DIV_W-1:0] r_pdiv [NUM_CH];
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_tick;
  logic              r_err;

  logic [DIV_W-1:0] w_cnt_nxt  [NUM_CH];
  logic [DIV_W-1:0] w_div_nxt  [NUM_CH];
  logic [DIV_W-1:0] w_pdiv_nxt [NUM_CH];
  logic [NUM_CH-1:0] w_pend_nxt;
  logic [NUM_CH-1:0] w_tick_nxt;
  logic [NUM_CH-1:0] w_term;
  logic [NUM_CH-1:0] w_restart;
  logic [NUM_CH-1:0] w_apply;
  logic [NUM_CH-1:0] w_take;
  logic              w_ready;
  logic              w_acc;
  logic              w_div_ok;

  // Ready depends only on the addressed channel's
  // pending flag; out-of-range channels never match.
  always_comb begin
    w_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_chan == CH_W'(i))
        w_ready = !r_pend[i];
    end
  end

  assign cfg.cfg_ready = w_ready;
  assign cfg.cfg_err   = r_err;
  assign tick          = r_tick;

  assign w_acc    = cfg.cfg_valid && w_ready;
  assign w_div_ok = cfg.cfg_div >= TWO;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_term[i] = ch_en[i] &&
        (r_cnt[i] == r_div[i] - ONE);
      w_restart[i] = sync || !ch_en[i] || w_term[i];
      // Pending divisor lands only on a period
      // boundary, so no short or long period leaks.
      w_apply[i] = r_pend[i] && w_restart[i];
      // A take needs pend clear, so it can never
      // collide with an apply on the same edge.
      w_take[i] = w_acc && w_div_ok &&
        (cfg.cfg_chan == CH_W'(i));
      w_div_nxt[i] = w_apply[i] ? r_pdiv[i]
                                : r_div[i];
      w_cnt_nxt[i] = w_restart[i] ? '0
                                  : r_cnt[i] + ONE;
      w_pend_nxt[i] = w_take[i] ||
        (r_pend[i] && !w_apply[i]);
      w_pdiv_nxt[i] = w_take[i] ? cfg.cfg_div
                                : r_pdiv[i];
      w_tick_nxt[i] = w_term[i] && !sync;
    end
  end

  always_ff @(posedge clk_125mhz) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i]  <= '0;
        r_div[i]  <= DEFAULT_DIVS[i*DIV_W +: DIV_W];
        r_pdiv[i] <= '0;
      end
      r_pend <= '0;
      r_tick <= '0;
      r_err  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i]  <= w_cnt_nxt[i];
        r_div[i]  <= w_div_nxt[i];
        r_pdiv[i] <= w_pdiv_nxt[i];
      end
      r_pend <= w_pend_nxt;
      r_tick <= w_tick_nxt;
      r_err  <= w_acc && !w_div_ok;
    end
  end

`ifdef TICK_SQUARE_EN
  logic [NUM_CH-1:0] r_sq;
  logic [NUM_CH-1:0] w_sq_nxt;

  // Registered from next-state count so sq lines up
  // with the count value of the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_sq_nxt[i] = ch_en[i] && !sync &&
        (w_cnt_nxt[i] >= (w_div_nxt[i] >> 1));
    end
  end

  always_ff @(posedge clk_125mhz) begin
    if (!reset_n)
      r_sq <= '0;
    else
      r_sq <= w_sq_nxt;
  end

  assign sq = r_sq;
`endif
endmodule
